// File: rtl/rv_pkg.sv
// -----------------------------------------------------------------------------
// rv_pkg
//   Shared RV32I definitions used by the fetch stage and by decode:
//   datapath width, reset vector, canonical NOP encoding and the bit
//   positions of the opcode / func3 / func7 fields inside an instruction word.
//   No ports (package).
// -----------------------------------------------------------------------------
package rv_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;  // addi x0, x0, 0

  // Instruction field slices
  localparam int OP_MSB    = 6;
  localparam int OP_LSB    = 0;
  localparam int FUNC3_MSB = 14;
  localparam int FUNC3_LSB = 12;
  localparam int FUNC7_MSB = 31;
  localparam int FUNC7_LSB = 25;

  localparam int OP_W    = OP_MSB - OP_LSB + 1;
  localparam int FUNC3_W = FUNC3_MSB - FUNC3_LSB + 1;
  localparam int FUNC7_W = FUNC7_MSB - FUNC7_LSB + 1;

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Small single-clock FIFO with a combinational view of the head entry.
//   Used both as the fetch PC tag queue and as the instruction buffer.
//
//   clk          in   1       clock, rising edge
//   rst          in   1       asynchronous reset, active-high (empties FIFO)
//   i_clr        in   1       synchronous flush (wins over push/pop)
//   i_push       in   1       write i_push_data at the tail
//   i_push_data  in   WIDTH   data to write
//   i_pop        in   1       drop the head entry
//   o_head       out  WIDTH   current head entry (valid when o_count != 0)
//   o_count      out  CW      number of stored entries
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic [CW-1:0]    o_count
);

  localparam int           PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL);
  assign w_pop   = i_pop && !w_empty;
  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign w_push  = i_push && (!w_full || w_pop);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through r_count.
  always_ff @(posedge clk) begin
    if (w_push && !i_clr) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//   RV32I instruction fetch stage. Owns the fetch PC, issues word requests to
//   instruction memory, buffers returned words and presents {pc, inst} plus
//   the opcode/func3/func7 fields to decode. Redirects flush the buffer and
//   arrange for responses of already-issued requests to be discarded.
//
//   clk             in   1     clock, rising edge
//   rst             in   1     asynchronous reset, active-high
//   imem_req_valid  out  1     fetch request valid
//   imem_req_ready  in   1     imem accepts request this cycle
//   imem_req_addr   out  XLEN  word-aligned fetch address
//   imem_rsp_valid  in   1     response valid (in request order, no back-pressure)
//   imem_rsp_data   in   32    instruction word
//   redirect_valid  in   1     branch/jump taken (1-cycle pulse)
//   redirect_pc     in   XLEN  target PC (bits [1:0] ignored)
//   id_ready        in   1     decode consumes the head this cycle
//   id_valid        out  1     head entry valid
//   id_inst         out  32    head instruction word
//   id_pc           out  XLEN  head instruction PC
//   id_op           out  7     opcode field of id_inst
//   id_func3        out  3     func3 field of id_inst
//   id_func7        out  7     func7 field of id_inst
// -----------------------------------------------------------------------------
module inst_fetch
  import rv_pkg::*;
#(
  parameter int              XLEN            = rv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC        = XLEN'(rv_pkg::RESET_PC),
  parameter int              FIFO_DEPTH      = 2,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            id_valid,
  output logic [31:0]     id_inst,
  output logic [XLEN-1:0] id_pc,
  output logic [6:0]      id_op,
  output logic [2:0]      id_func3,
  output logic [6:0]      id_func7
);

  localparam int OC_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int FC_W = $clog2(FIFO_DEPTH + 1);
  localparam int EW   = XLEN + 32;

  logic [XLEN-1:0] r_fetch_pc;
  logic [OC_W-1:0] r_drop_cnt;

  // The tag queue holds exactly one entry per request in flight, so its
  // occupancy is the outstanding-request count.
  logic [OC_W-1:0] w_outstanding;
  logic [XLEN-1:0] w_tag_pc;
  logic [FC_W-1:0] w_buf_count;
  logic [EW-1:0]   w_buf_head;

  logic [31:0]     w_live_inflight;
  logic            w_credit_ok;
  logic            w_slot_ok;
  logic            w_req_fire;
  logic            w_rsp_drop;
  logic            w_buf_push;
  logic            w_buf_pop;
  logic [OC_W-1:0] w_outstanding_after_rsp;

  // Requests whose words will actually land in the buffer, plus what is
  // already buffered, must fit in the buffer. Counts are the registered
  // ones, so a pop this cycle does not free a slot until the next cycle.
  assign w_live_inflight = 32'(w_outstanding) - 32'(r_drop_cnt);
  assign w_credit_ok     = (w_live_inflight + 32'(w_buf_count)) < 32'(FIFO_DEPTH);
  assign w_slot_ok       = 32'(w_outstanding) < 32'(MAX_OUTSTANDING);

  assign imem_req_valid  = !rst && !redirect_valid && w_slot_ok && w_credit_ok;
  assign imem_req_addr   = r_fetch_pc;
  assign w_req_fire      = imem_req_valid && imem_req_ready;

  assign w_rsp_drop      = imem_rsp_valid && (r_drop_cnt != '0);
  // A response in the redirect cycle belongs to the old path.
  assign w_buf_push      = imem_rsp_valid && !w_rsp_drop && !redirect_valid;
  assign w_buf_pop       = id_valid && id_ready;

  assign w_outstanding_after_rsp =
    (imem_rsp_valid && (w_outstanding != '0)) ? w_outstanding - OC_W'(1) : w_outstanding;

  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_q (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (1'b0),
    .i_push      (w_req_fire),
    .i_push_data (r_fetch_pc),
    .i_pop       (imem_rsp_valid),
    .o_head      (w_tag_pc),
    .o_count     (w_outstanding)
  );

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_inst_buf (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (redirect_valid),
    .i_push      (w_buf_push),
    .i_push_data ({w_tag_pc, imem_rsp_data}),
    .i_pop       (w_buf_pop),
    .o_head      (w_buf_head),
    .o_count     (w_buf_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_drop_cnt <= '0;
    end else begin
      if (redirect_valid) begin
        r_fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
        // Every request still in flight after this cycle is on the old path.
        r_drop_cnt <= w_outstanding_after_rsp;
      end else begin
        if (w_req_fire) r_fetch_pc <= r_fetch_pc + XLEN'(4);
        if (w_rsp_drop) r_drop_cnt <= r_drop_cnt - OC_W'(1);
      end
    end
  end

  assign id_valid = (w_buf_count != '0);
  assign id_pc    = w_buf_head[EW-1:32];
  assign id_inst  = w_buf_head[31:0];
  assign id_op    = id_inst[OP_MSB:OP_LSB];
  assign id_func3 = id_inst[FUNC3_MSB:FUNC3_LSB];
  assign id_func7 = id_inst[FUNC7_MSB:FUNC7_LSB];

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
//   Self-checking bench for inst_fetch. A memory model answers accepted
//   requests in order after a random latency; a reference model tracks the
//   expected fetch address, the set of requests in flight (tagged with the
//   redirect epoch that issued them) and the expected decode queue.
// -----------------------------------------------------------------------------
module tb_inst_fetch;

  localparam int          FIFO_DEPTH = 2;
  localparam int          MAX_OUT    = 2;
  localparam logic [31:0] RST_PC     = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [6:0]  id_op;
  logic [2:0]  id_func3;
  logic [6:0]  id_func7;

  inst_fetch #(
    .XLEN            (32),
    .RESET_PC        (RST_PC),
    .FIFO_DEPTH      (FIFO_DEPTH),
    .MAX_OUTSTANDING (MAX_OUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .id_inst        (id_inst),
    .id_pc          (id_pc),
    .id_op          (id_op),
    .id_func3       (id_func3),
    .id_func7       (id_func7)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } pend_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } head_t;

  pend_t       pend[$];   // requests in flight, oldest first
  head_t       q[$];      // words decode should see, oldest first
  logic [31:0] exp_pc;
  int          epoch;
  int          cyc;
  int          last_due;
  int          n_checks;
  int          n_fail;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5C3_0F17;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs against the model,
  // then advance the model by what happens at the coming rising edge.
  task automatic step(input bit rdy, input bit idr, input bit redir,
                      input logic [31:0] tgt, input int maxlat);
    pend_t       p;
    head_t       h;
    bit          rsp;
    bit          exp_rv;
    int          live;
    int          lat;
    logic [31:0] w;
    @(negedge clk);
    rsp = (pend.size() > 0) && (pend[0].due <= cyc);
    imem_req_ready = rdy;
    id_ready       = idr;
    redirect_valid = redir;
    redirect_pc    = tgt;
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_word(pend[0].addr) : $urandom;
    #1;
    live = 0;
    foreach (pend[i]) if (pend[i].epoch == epoch) live++;
    exp_rv = !redir && (pend.size() < MAX_OUT) && ((live + q.size()) < FIFO_DEPTH);
    check_eq("req_valid", 64'(imem_req_valid), 64'(exp_rv));
    if (imem_req_valid && exp_rv) check_eq("req_addr", 64'(imem_req_addr), 64'(exp_pc));
    check_eq("id_valid", 64'(id_valid), 64'(q.size() != 0));
    if (q.size() != 0 && id_valid) begin
      h = q[0];
      w = h.inst;
      check_eq("id_pc", 64'(id_pc), 64'(h.pc));
      check_eq("id_inst", 64'(id_inst), 64'(h.inst));
      check_eq("id_op", 64'(id_op), 64'(w[6:0]));
      check_eq("id_func3", 64'(id_func3), 64'(w[14:12]));
      check_eq("id_func7", 64'(id_func7), 64'(w[31:25]));
    end
    // Model update for the edge at the end of this cycle.
    if (q.size() != 0 && idr) begin
      h = q.pop_front();
      $display("retire cyc=%0d pc=%08h inst=%08h", cyc, h.pc, h.inst);
    end
    if (redir) begin
      q.delete();
      epoch++;
      exp_pc = {tgt[31:2], 2'b00};
    end
    if (rsp) begin
      p = pend.pop_front();
      if (p.epoch == epoch) begin
        h.pc   = p.addr;
        h.inst = mem_word(p.addr);
        q.push_back(h);
      end
    end
    if (imem_req_valid && rdy) begin
      lat     = (maxlat < 1) ? 1 : $urandom_range(1, maxlat);
      p.addr  = imem_req_addr;
      p.epoch = epoch;
      p.due   = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      last_due = p.due;
      pend.push_back(p);
      exp_pc = exp_pc + 32'd4;
    end
    cyc++;
  endtask

  task automatic model_reset();
    q.delete();
    pend.delete();
    exp_pc   = RST_PC;
    epoch++;
    last_due = cyc - 1;
  endtask

  // Reset asserted between clock edges; outputs must drop without waiting
  // for a clock. Ready is held low across the release cycle so nothing is
  // accepted outside the stepped model.
  task automatic reset_mid();
    @(negedge clk);
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    id_ready       = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("rst_req_valid", 64'(imem_req_valid), 64'(0));
    check_eq("rst_id_valid", 64'(id_valid), 64'(0));
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] tgt;
    bit          found;
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    epoch    = 0;
    last_due = -1;
    exp_pc   = RST_PC;
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    id_ready       = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    check_eq("reset_req_valid", 64'(imem_req_valid), 64'(0));
    check_eq("reset_id_valid", 64'(id_valid), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // Streaming with ready memory and 1-cycle latency.
    repeat (40) step(1'b1, 1'b1, 1'b0, 32'h0, 1);

    // Decode stalls for 10 cycles, then drains.
    repeat (10) step(1'b1, 1'b0, 1'b0, 32'h0, 1);
    repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0, 1);

    // Redirect to 0x100 with two requests in flight.
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (pend.size() == MAX_OUT) begin
        found = 1'b1;
        break;
      end
      step(1'b1, 1'b1, 1'b0, 32'h0, 3);
    end
    check_eq("s3_two_in_flight", 64'(found), 64'(1));
    step(1'b1, 1'b1, 1'b1, 32'h0000_0100, 3);
    repeat (20) step(1'b1, 1'b1, 1'b0, 32'h0, 3);

    // Redirect to 0x203 in a cycle with a response and a decode pop.
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (pend.size() > 0 && pend[0].due <= cyc && q.size() > 0) begin
        step(1'b1, 1'b1, 1'b1, 32'h0000_0203, 2);
        found = 1'b1;
        break;
      end
      step(1'b1, ($urandom_range(0, 3) == 0), 1'b0, 32'h0, 2);
    end
    check_eq("s4_redirect_rsp_pop", 64'(found), 64'(1));
    repeat (20) step(1'b1, 1'b1, 1'b0, 32'h0, 2);

    // Memory not ready for 5 cycles.
    repeat (5) step(1'b0, 1'b1, 1'b0, 32'h0, 1);
    repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0, 1);

    // Reset in the middle of traffic.
    repeat (5) step(1'b1, 1'b1, 1'b0, 32'h0, 2);
    reset_mid();
    repeat (20) step(1'b1, 1'b1, 1'b0, 32'h0, 1);

    // Randomized traffic, including redirects near the top of the address space.
    for (int i = 0; i < 3000; i++) begin
      tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 29) == 0), tgt, $urandom_range(1, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
